// File: rtl/riscv_pkg.sv
// Shared register-file definitions: state encoding,
// register count and address width.
package riscv_pkg;

    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef logic [AW-1:0] reg_addr_t;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_port_ctrl_if.sv
// Bundle of core write, debug request/response and
// register-file port signals around regfile_port_ctrl.
interface regfile_port_ctrl_if #(
    parameter int DWIDTH = 32
);
    import riscv_pkg::*;

    logic              core_wr_valid;
    reg_addr_t         core_wr_addr;
    logic [DWIDTH-1:0] core_wr_data;
    logic              core_wr_ready;

    logic              dbg_req_valid;
    logic              dbg_req_we;
    reg_addr_t         dbg_req_addr;
    logic [DWIDTH-1:0] dbg_req_wdata;
    logic              dbg_req_ready;
    logic              dbg_rsp_valid;
    logic [DWIDTH-1:0] dbg_rsp_rdata;

    logic              rf_wr;
    reg_addr_t         rf_addr_d;
    logic [DWIDTH-1:0] rf_data_d;
    reg_addr_t         rf_addr_dbg;
    logic [DWIDTH-1:0] rf_data_dbg;

    logic              init_busy;

    modport master (
        output core_wr_valid, core_wr_addr, core_wr_data,
        input  core_wr_ready,
        output dbg_req_valid, dbg_req_we, dbg_req_addr,
        output dbg_req_wdata,
        input  dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata,
        input  rf_wr, rf_addr_d, rf_data_d, rf_addr_dbg,
        output rf_data_dbg,
        input  init_busy
    );

    modport slave (
        input  core_wr_valid, core_wr_addr, core_wr_data,
        output core_wr_ready,
        input  dbg_req_valid, dbg_req_we, dbg_req_addr,
        input  dbg_req_wdata,
        output dbg_req_ready, dbg_rsp_valid, dbg_rsp_rdata,
        output rf_wr, rf_addr_d, rf_data_d, rf_addr_dbg,
        input  rf_data_dbg,
        output init_busy
    );

endinterface

// File: rtl/regfile_wr_arb.sv
// Core-priority write arbiter with a saturating starvation
// counter that lets a blocked debug write through.
module regfile_wr_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_core_valid,
    input  logic i_dbg_valid,
    output logic o_grant_core,
    output logic o_grant_dbg
);

    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] r_starve_cnt;
    logic          w_starved;

    assign w_starved = (r_starve_cnt == CW'(STARVE_MAX));

    assign o_grant_dbg  = i_en & i_dbg_valid
                        & (~i_core_valid | w_starved);
    assign o_grant_core = i_en & i_core_valid
                        & ~(i_dbg_valid & w_starved);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (!i_en || !i_dbg_valid || o_grant_dbg) begin
            r_starve_cnt <= '0;
        end else if (!w_starved) begin
            r_starve_cnt <= r_starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// Register-file port controller: post-reset clear sweep,
// core/debug write arbitration and registered debug reads.
module regfile_port_ctrl
    import riscv_pkg::*;
#(
    parameter int DWIDTH     = 32,
    parameter int STARVE_MAX = 4
) (
    input logic               clk,
    input logic               rst,
    regfile_port_ctrl_if.slave bus
);

    rf_state_e         r_state;
    reg_addr_t         r_clr_ptr;
    logic              r_rsp_valid;
    logic [DWIDTH-1:0] r_rsp_rdata;

    logic              w_clear;
    logic              w_run;
    logic              w_dbg_wr;
    logic              w_rd_acc;
    logic              w_grant_core;
    logic              w_grant_dbg;
    logic              w_rf_wr;
    reg_addr_t         w_rf_addr;
    logic [DWIDTH-1:0] w_rf_data;

    assign w_clear  = !rst && (r_state == CLEAR);
    assign w_run    = !rst && (r_state == RUN);
    assign w_dbg_wr = bus.dbg_req_valid & bus.dbg_req_we;
    assign w_rd_acc = w_run & bus.dbg_req_valid & ~bus.dbg_req_we;

    regfile_wr_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .i_en         (w_run),
        .i_core_valid (bus.core_wr_valid),
        .i_dbg_valid  (w_dbg_wr),
        .o_grant_core (w_grant_core),
        .o_grant_dbg  (w_grant_dbg)
    );

    // Writes to x0 are acknowledged but never reach the array.
    always_comb begin
        w_rf_wr   = 1'b0;
        w_rf_addr = w_grant_dbg ? bus.dbg_req_addr : bus.core_wr_addr;
        w_rf_data = w_grant_dbg ? bus.dbg_req_wdata : bus.core_wr_data;
        if (w_clear) begin
            w_rf_wr   = 1'b1;
            w_rf_addr = r_clr_ptr;
            w_rf_data = '0;
        end else if (w_grant_core || w_grant_dbg) begin
            w_rf_wr = (w_rf_addr != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= CLEAR;
            r_clr_ptr   <= AW'(1);
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rsp_rdata <= (bus.dbg_req_addr == '0) ? '0
                                                        : bus.rf_data_dbg;
            end
            unique case (r_state)
                CLEAR: begin
                    r_clr_ptr <= r_clr_ptr + AW'(1);
                    if (r_clr_ptr == AW'(NREG - 1)) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_clr_ptr <= r_clr_ptr;
                end
            endcase
        end
    end

    assign bus.core_wr_ready = w_grant_core;
    assign bus.dbg_req_ready = w_grant_dbg | w_rd_acc;
    assign bus.dbg_rsp_valid = r_rsp_valid & ~rst;
    assign bus.dbg_rsp_rdata = rst ? '0 : r_rsp_rdata;
    assign bus.rf_wr         = w_rf_wr;
    assign bus.rf_addr_d     = w_rf_addr;
    assign bus.rf_data_d     = w_rf_data;
    assign bus.rf_addr_dbg   = bus.dbg_req_addr;
    assign bus.init_busy     = rst | (r_state == CLEAR);

endmodule

// File: tb/tb_regfile_port_ctrl.sv
// Bench for regfile_port_ctrl: vector table plus hand
// sequences for clear, starvation and reset corners.
module tb_regfile_port_ctrl;
    import riscv_pkg::*;

    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_port_ctrl_if #(.DWIDTH(DW)) bus ();

    regfile_port_ctrl #(
        .DWIDTH     (DW),
        .STARVE_MAX (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] env_rf   [NREG];
    logic [DW-1:0] model_rf [NREG];
    logic [DW-1:0] rsp_q [$];

    int checks   = 0;
    int failures = 0;

    assign bus.rf_data_dbg = env_rf[bus.rf_addr_dbg];

    always @(posedge clk) begin
        if (bus.rf_wr) env_rf[bus.rf_addr_d] <= bus.rf_data_d;
    end

    typedef struct {
        logic          cv;
        logic [4:0]    ca;
        logic [DW-1:0] cd;
        logic          dv;
        logic          dwe;
        logic [4:0]    da;
        logic [DW-1:0] dd;
        logic          e_cr;
        logic          e_dr;
        logic          e_wr;
        logic [4:0]    e_a;
        logic [DW-1:0] e_d;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_rsp();
        chk("rsp_valid", DW'(bus.dbg_rsp_valid), DW'(rsp_q.size() > 0));
        if (rsp_q.size() > 0) chk("rsp_rdata", bus.dbg_rsp_rdata, rsp_q.pop_front());
    endtask

    task automatic drive(input logic cv, input logic [4:0] ca,
                         input logic [DW-1:0] cd, input logic dv,
                         input logic dwe, input logic [4:0] da,
                         input logic [DW-1:0] dd);
        bus.core_wr_valid = cv;
        bus.core_wr_addr  = ca;
        bus.core_wr_data  = cd;
        bus.dbg_req_valid = dv;
        bus.dbg_req_we    = dwe;
        bus.dbg_req_addr  = da;
        bus.dbg_req_wdata = dd;
    endtask

    task automatic neg();
        @(negedge clk);
        check_rsp();
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'h1111, 1'b1, 1'b0, 5'd3, 32'h0);
        pos();
        neg();
        chk("rst_rf_wr", DW'(bus.rf_wr), 0);
        chk("rst_core_rdy", DW'(bus.core_wr_ready), 0);
        chk("rst_dbg_rdy", DW'(bus.dbg_req_ready), 0);
        chk("rst_busy", DW'(bus.init_busy), 1);
        chk("rst_rdata", bus.dbg_rsp_rdata, 0);
        pos();
        rst = 1'b0;
    endtask

    // stop_at = 0 runs the whole sweep into RUN
    task automatic clear_seq(input int stop_at);
        drive(1'b1, 5'd2, 32'hABCD, 1'b1, 1'b1, 5'd4, 32'h99);
        for (int i = 1; i <= 31; i++) begin
            neg();
            chk("clr_wr", DW'(bus.rf_wr), 1);
            chk("clr_addr", DW'(bus.rf_addr_d), DW'(i));
            chk("clr_data", bus.rf_data_d, 0);
            chk("clr_busy", DW'(bus.init_busy), 1);
            chk("clr_core_rdy", DW'(bus.core_wr_ready), 0);
            chk("clr_dbg_rdy", DW'(bus.dbg_req_ready), 0);
            if (i == stop_at) return;
            pos();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        for (int r = 0; r < NREG; r++) model_rf[r] = '0;
        neg();
        chk("run_busy", DW'(bus.init_busy), 0);
        chk("run_idle_wr", DW'(bus.rf_wr), 0);
        pos();
    endtask

    initial begin
        for (int r = 0; r < NREG; r++) begin
            env_rf[r]   = 32'hBAD0_0000 + DW'(r);
            model_rf[r] = '0;
        end

        tbl[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 1'b0, 5'd5,  32'h0,
                    1'b1, 1'b1, 1'b1, 5'd5,  32'hDEADBEEF};
        tbl[1]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd5,  32'h0,
                    1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd9,  32'hA5A5,
                    1'b0, 1'b1, 1'b1, 5'd9,  32'hA5A5};
        tbl[3]  = '{1'b1, 5'd3,  32'h33,       1'b1, 1'b1, 5'd10, 32'h77,
                    1'b1, 1'b0, 1'b1, 5'd3,  32'h33};
        tbl[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0,  32'h0,
                    1'b0, 1'b0, 1'b0, 5'd0,  32'h0};
        tbl[5]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 1'b0, 5'd0,  32'h0,
                    1'b1, 1'b0, 1'b0, 5'd0,  32'h0};
        tbl[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd0,  32'h0,
                    1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd9,  32'h0,
                    1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b1, 5'd0,  32'h55,
                    1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[9]  = '{1'b1, 5'd31, 32'h1F1F,     1'b1, 1'b0, 5'd3,  32'h0,
                    1'b1, 1'b1, 1'b1, 5'd31, 32'h1F1F};
        tbl[10] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd31, 32'h0,
                    1'b0, 1'b1, 1'b0, 5'd0,  32'h0};
        tbl[11] = '{1'b1, 5'd6,  32'h66,       1'b1, 1'b1, 5'd10, 32'h88,
                    1'b1, 1'b0, 1'b1, 5'd6,  32'h66};
        tbl[12] = '{1'b0, 5'd0,  32'h0,        1'b1, 1'b0, 5'd6,  32'h0,
                    1'b0, 1'b1, 1'b0, 5'd0,  32'h0};

        do_reset();
        clear_seq(0);

        foreach (tbl[i]) begin
            drive(tbl[i].cv, tbl[i].ca, tbl[i].cd, tbl[i].dv,
                  tbl[i].dwe, tbl[i].da, tbl[i].dd);
            neg();
            chk($sformatf("v%0d_core_rdy", i), DW'(bus.core_wr_ready), DW'(tbl[i].e_cr));
            chk($sformatf("v%0d_dbg_rdy", i), DW'(bus.dbg_req_ready), DW'(tbl[i].e_dr));
            chk($sformatf("v%0d_rf_wr", i), DW'(bus.rf_wr), DW'(tbl[i].e_wr));
            if (tbl[i].e_wr) begin
                chk($sformatf("v%0d_addr", i), DW'(bus.rf_addr_d), DW'(tbl[i].e_a));
                chk($sformatf("v%0d_data", i), bus.rf_data_d, tbl[i].e_d);
            end
            if (tbl[i].dv && !tbl[i].dwe && tbl[i].e_dr)
                rsp_q.push_back(model_rf[tbl[i].da]);
            if (tbl[i].e_wr) model_rf[tbl[i].e_a] = tbl[i].e_d;
            pos();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        neg();
        pos();

        // starvation: debug write must win on the fifth blocked cycle
        for (int i = 1; i <= 6; i++) begin
            drive(1'b1, 5'd4, 32'h100 + DW'(i), i <= 5, 1'b1, 5'd7, 32'h12345678);
            neg();
            chk($sformatf("st%0d_core_rdy", i), DW'(bus.core_wr_ready), DW'(i != 5));
            chk($sformatf("st%0d_dbg_rdy", i), DW'(bus.dbg_req_ready), DW'(i == 5));
            chk($sformatf("st%0d_wr", i), DW'(bus.rf_wr), 1);
            chk($sformatf("st%0d_addr", i), DW'(bus.rf_addr_d), (i == 5) ? 7 : 4);
            if (i == 5) begin
                chk("st_data_dbg", bus.rf_data_d, 32'h12345678);
                model_rf[7] = 32'h12345678;
            end else begin
                chk($sformatf("st%0d_data", i), bus.rf_data_d, 32'h100 + DW'(i));
                model_rf[4] = 32'h100 + DW'(i);
            end
            pos();
        end
        foreach (tbl[k]) begin
            if (k > 1) break;
            drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, (k == 0) ? 5'd7 : 5'd4, 32'h0);
            neg();
            chk("rb_dbg_rdy", DW'(bus.dbg_req_ready), 1);
            rsp_q.push_back(model_rf[(k == 0) ? 7 : 4]);
            pos();
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        neg();
        pos();

        // read accepted, then reset before the response can appear
        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0);
        neg();
        chk("drop_rd_rdy", DW'(bus.dbg_req_ready), 1);
        pos();
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        neg();
        chk("drop_rsp_valid", DW'(bus.dbg_rsp_valid), 0);
        do_reset();
        neg();
        chk("drop_after_rst", DW'(bus.dbg_rsp_valid), 0);
        pos();
        rst = 1'b1;
        do_reset();

        // reset in the middle of the clear sweep
        clear_seq(17);
        do_reset();
        clear_seq(0);

        drive(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd9, 32'h0);
        neg();
        chk("final_rd_rdy", DW'(bus.dbg_req_ready), 1);
        rsp_q.push_back(model_rf[9]);
        pos();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
        neg();
        pos();
        chk("q_empty", DW'(rsp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_port_ctrl.md
REGFILE_PORT_CTRL -- requirements
Module: regfile_port_ctrl

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 32, which is the register data width.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, which is the number of consecutive blocked cycles before a debug write is forced through.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port core_wr_valid, input, 1 bit: the core writeback request.
REQ-006 The block SHALL have ports core_wr_addr (input, 5 bits) and core_wr_data (input, DWIDTH bits): the core write target and value.
REQ-007 The block SHALL have port core_wr_ready, output, 1 bit: the core write was accepted this cycle.
REQ-008 The block SHALL have port dbg_req_valid, input, 1 bit: the debug request.
REQ-009 The block SHALL have port dbg_req_we, input, 1 bit: 1 = debug write, 0 = debug read.
REQ-010 The block SHALL have ports dbg_req_addr (input, 5 bits) and dbg_req_wdata (input, DWIDTH bits): the debug target and write value.
REQ-011 The block SHALL have port dbg_req_ready, output, 1 bit: the debug request was accepted this cycle.
REQ-012 The block SHALL have ports dbg_rsp_valid (output, 1 bit) and dbg_rsp_rdata (output, DWIDTH bits): the debug read response.
REQ-013 The block SHALL have ports rf_wr (output, 1 bit), rf_addr_d (output, 5 bits) and rf_data_d (output, DWIDTH bits): the register-file write port.
REQ-014 The block SHALL have ports rf_addr_dbg (output, 5 bits) and rf_data_dbg (input, DWIDTH bits): the register-file combinational read port used for debug.
REQ-015 The block SHALL have port init_busy, output, 1 bit: the clear sequence is in progress.

Function
REQ-016 The FSM SHALL have exactly two states, CLEAR and RUN, and SHALL enter CLEAR on reset.
REQ-017 In CLEAR:
- the block SHALL drive rf_wr=1 and rf_data_d=0, with rf_addr_d stepping 1,2,...,31, one address per cycle;
- after address 31 it SHALL transition to RUN, so that CLEAR lasts 31 cycles.
REQ-018 In CLEAR, core_wr_ready and dbg_req_ready SHALL be 0 and init_busy SHALL be 1; in RUN, init_busy SHALL be 0.
REQ-019 In RUN, at most one write SHALL be granted per cycle, and the write outputs SHALL be combinational from the granted request (no added latency).
REQ-020 Write arbitration: the core SHALL have priority, except that when starve_cnt==STARVE_MAX a pending debug write SHALL win for that cycle.
REQ-021 starve_cnt behaviour:
- it SHALL increment on every cycle in which a debug write is valid but not granted, saturating at STARVE_MAX;
- it SHALL clear when a debug write is granted or when no debug write is pending.
REQ-022 A granted write to address 0 SHALL be accepted (ready=1) but SHALL drive rf_wr=0.
REQ-023 A debug read SHALL always be accepted in RUN, independent of the write arbitration, with rf_addr_dbg=dbg_req_addr.
REQ-024 Debug read response:
- dbg_rsp_valid SHALL be 1 for exactly one cycle, the cycle after read acceptance, carrying the registered rf_data_dbg;
- the response SHALL have no backpressure.
- A read of address 0 SHALL return 0.
REQ-025 A debug read that coincides with a core write to the same address SHALL return the value from before that write.
REQ-026 Debug writes SHALL produce no response.
REQ-027 When no write is granted, rf_wr SHALL be 0.

Reset
REQ-028 While rst=1, the block SHALL set: state=CLEAR, clear pointer=1, starve_cnt=0, dbg_rsp_valid=0, dbg_rsp_rdata=0, both readies=0, rf_wr=0 and init_busy=1.
REQ-029 A reset asserted mid-CLEAR or mid-RUN SHALL restart the clear at address 1, and a pending debug read response SHALL be dropped.

Structure
REQ-030 The state encoding, the register-count constant NREG=32 and the address width 5 SHALL reside in the shared package riscv_pkg.
REQ-031 The arbitration (priority plus starvation counter) SHALL be one sub-module, regfile_wr_arb; the FSM and the read path SHALL remain in the top module.

Verification
REQ-032 Release rst and idle -> rf_wr=1 for 31 cycles with addresses 1..31 and data 0, then init_busy=0 and core_wr_ready usable.
REQ-033 In RUN, core write addr 5 with data 0xDEADBEEF and simultaneous debug read addr 5 -> core_wr_ready=1, and one cycle later dbg_rsp_rdata equals the old value (0).
REQ-034 Core valid every cycle with a debug write pending (addr 7, data 0x12345678) -> the debug write is granted on the 5th cycle (STARVE_MAX=4), and the core is stalled exactly that cycle.
REQ-035 Core write addr 0 with data 0xFFFFFFFF -> core_wr_ready=1 and rf_wr=0; a subsequent debug read of addr 0 returns 0.
REQ-036 Assert rst at CLEAR pointer 17 -> the sequence restarts at address 1, and the full 31 writes complete before RUN.
REQ-037 Debug read accepted, then rst in the following cycle -> dbg_rsp_valid stays 0.
